sram_port_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the instruction-fetch requester (inst_*) and the load/store requester (data_*). This is the step toward a single-bus core with an AXI bridge.
- Data requests have fixed priority over instruction requests. A starvation counter bounds how long an instruction request can be held off.
- A small in-order owner FIFO routes each returned data_ok/rdata to the requester that issued the transaction.
- Sits between the IFU/EXU/MEMU sram interfaces and the external memory port.

---
 rtl/sram_port_arbiter.sv | 107 ++++++++++
 tb/tb_sram_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like memory port between inst and data requesters
// Ports:
//   clk, resetn                  clock (rising edge), asynchronous active-low reset
//   inst_* / data_* (inputs)     requester side: req, wr, size, wstrb, addr, wdata
//   inst_* / data_* (outputs)    addr_ok (accepted), data_ok (response), rdata
//   mem_* (outputs)              downstream request: req, wr, size, wstrb, addr, wdata
//   mem_addr_ok, mem_data_ok,    downstream accept, in-order response and read data
//   mem_rdata
//   outst_cnt                    accepted-but-unreturned transaction count
//   resp_err                     sticky: a response arrived with nothing outstanding
module sram_port_arbiter #(
   parameter int MAX_OUTST  = 4,
   parameter int STARVE_LIM = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  outst_cnt,
   output logic        resp_err
);
   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   logic                 lock_vld, lock_owner;
   logic [3:0]           starve_cnt;
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [MAX_OUTST-1:0] owner_q;
   logic                 gnt_vld, gnt_data, req_g, full, acc, pop, head;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
   endfunction

   // A request left waiting on mem_addr_ok stays locked to its owner until accepted
   assign gnt_vld  = lock_vld | data_req | inst_req;
   assign gnt_data = lock_vld ? lock_owner
                              : data_req & ~(inst_req & (starve_cnt == 4'(STARVE_LIM)));
   assign req_g    = gnt_data ? data_req : inst_req;
   // Full is taken from the registered count, so a same-cycle pop does not reopen the port
   assign full     = outst_cnt == 4'(MAX_OUTST);
   assign mem_req  = resetn & gnt_vld & req_g & ~full;
   assign mem_wr    = gnt_vld & (gnt_data ? data_wr : inst_wr);
   assign mem_size  = gnt_vld ? (gnt_data ? data_size  : inst_size)  : '0;
   assign mem_wstrb = gnt_vld ? (gnt_data ? data_wstrb : inst_wstrb) : '0;
   assign mem_addr  = gnt_vld ? (gnt_data ? data_addr  : inst_addr)  : '0;
   assign mem_wdata = gnt_vld ? (gnt_data ? data_wdata : inst_wdata) : '0;
   assign acc          = mem_req & mem_addr_ok;
   assign data_addr_ok = acc & gnt_data;
   assign inst_addr_ok = acc & ~gnt_data;
   assign pop          = mem_data_ok & (outst_cnt != '0);
   assign head         = owner_q[rd_ptr];
   assign data_data_ok = pop & head;
   assign inst_data_ok = pop & ~head;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         lock_vld   <= 1'b0;
         lock_owner <= 1'b0;
         starve_cnt <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         owner_q    <= '0;
         outst_cnt  <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (acc) lock_vld <= 1'b0;
         else if (mem_req) begin
            lock_vld   <= 1'b1;
            lock_owner <= gnt_data;
         end
         if (!inst_req || (acc && !gnt_data)) starve_cnt <= '0;
         else if (acc && starve_cnt != 4'(STARVE_LIM)) starve_cnt <= starve_cnt + 4'd1;
         if (acc) begin
            owner_q[wr_ptr] <= gnt_data;
            wr_ptr          <= nxt(wr_ptr);
         end
         if (pop) rd_ptr <= nxt(rd_ptr);
         outst_cnt <= outst_cnt + {3'd0, acc} - {3'd0, pop};
         if (mem_data_ok && outst_cnt == '0) resp_err <= 1'b1;
      end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: self-checking bench for sram_port_arbiter (vectors, corner sequences, random vs model)
// Ports: none
module tb_sram_port_arbiter;
   localparam int MO = 4;
   localparam int SL = 3;
   logic        clk = 1'b0, resetn = 1'b0;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb, outst_cnt;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        resp_err;

   sram_port_arbiter #(.MAX_OUTST(MO), .STARVE_LIM(SL)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .outst_cnt(outst_cnt), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ir, dr, aok, dok;
      logic [31:0] ia, rd;
      logic        eia, eda, eid, edd;
      logic [3:0]  ec;
   } vec_t;
   vec_t tbl[$];

   int n_cmp = 0, n_bad = 0;
   // Reference model: queue of transaction owners (1 = data), requester holding the port, streak of data wins
   int m_q[$];
   int m_lock, m_streak, g;
   bit m_err, e_req, e_acc, e_pop, e_head;

   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, a, e);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_lock = -1;
      m_streak = 0;
      m_err = 0;
   endtask

   task automatic model_comb();
      int n = m_q.size();
      if (m_lock >= 0) g = m_lock;
      else if (data_req && !(inst_req && m_streak == SL)) g = 1;
      else if (inst_req) g = 0;
      else g = -1;
      e_req  = (g == 1 ? data_req : g == 0 ? inst_req : 1'b0) && n < MO;
      e_acc  = e_req && mem_addr_ok;
      e_pop  = mem_data_ok && n > 0;
      e_head = n > 0 && m_q[0] == 1;
   endtask

   task automatic model_seq();
      int n = m_q.size();
      if (mem_data_ok && n == 0) m_err = 1;
      if (e_pop) void'(m_q.pop_front());
      if (e_acc) m_q.push_back(g);
      if (e_acc) m_lock = -1;
      else if (e_req) m_lock = g;
      if (!inst_req || (e_acc && g == 0)) m_streak = 0;
      else if (e_acc && g == 1 && m_streak < SL) m_streak++;
   endtask

   task automatic settle();
      logic [70:0] e_bus;
      #1;
      model_comb();
      e_bus = (g == 1) ? {data_wr, data_size, data_wstrb, data_addr, data_wdata} :
              (g == 0) ? {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata} : '0;
      chk("ctl", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, resp_err, outst_cnt},
          {e_acc && g == 0, e_acc && g == 1, e_pop && !e_head, e_pop && e_head, e_req, m_err, 4'(m_q.size())});
      chk("bus", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, e_bus);
      chk("rdata", {inst_rdata, data_rdata}, {mem_rdata, mem_rdata});
   endtask

   task automatic adv();
      @(posedge clk);
      model_seq();
      @(negedge clk);
   endtask

   task automatic zero_inputs();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf; data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      resetn = 0;
      zero_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      resetn = 1;
   endtask

   initial begin
      bit hold_i, hold_d;
      int accepts;
      logic [1:0] ord[4];
      zero_inputs();
      do_reset();
      // Reset state
      settle();
      chk("reset", {mem_req, outst_cnt, resp_err, inst_addr_ok, data_addr_ok}, 8'h0);
      adv();

      // Inst-only reads, then both requesters held: grants D,D,D,I,D,D,D,I
      tbl.push_back('{1, 0, 1, 0, 32'h1c000000, 32'h0,  1, 0, 0, 0, 4'd0});
      tbl.push_back('{1, 0, 1, 1, 32'h1c000004, 32'h11, 1, 0, 1, 0, 4'd1});
      tbl.push_back('{0, 0, 1, 1, 32'h0,        32'h22, 0, 0, 1, 0, 4'd1});
      tbl.push_back('{0, 0, 1, 0, 32'h0,        32'h0,  0, 0, 0, 0, 4'd0});
      tbl.push_back('{1, 1, 1, 0, 32'h1c000100, 32'h0,  0, 1, 0, 0, 4'd0});
      tbl.push_back('{1, 1, 1, 1, 32'h1c000100, 32'h1,  0, 1, 0, 1, 4'd1});
      tbl.push_back('{1, 1, 1, 1, 32'h1c000100, 32'h2,  0, 1, 0, 1, 4'd1});
      tbl.push_back('{1, 1, 1, 1, 32'h1c000100, 32'h3,  1, 0, 0, 1, 4'd1});
      tbl.push_back('{1, 1, 1, 1, 32'h1c000100, 32'h4,  0, 1, 1, 0, 4'd1});
      tbl.push_back('{1, 1, 1, 1, 32'h1c000100, 32'h5,  0, 1, 0, 1, 4'd1});
      tbl.push_back('{1, 1, 1, 1, 32'h1c000100, 32'h6,  0, 1, 0, 1, 4'd1});
      tbl.push_back('{1, 1, 1, 1, 32'h1c000100, 32'h7,  1, 0, 0, 1, 4'd1});
      tbl.push_back('{0, 0, 1, 1, 32'h0,        32'h8,  0, 0, 1, 0, 4'd1});
      tbl.push_back('{0, 0, 1, 0, 32'h0,        32'h0,  0, 0, 0, 0, 4'd0});
      data_addr = 32'h100;
      for (int i = 0; i < tbl.size(); i++) begin
         inst_req = tbl[i].ir; data_req = tbl[i].dr; mem_addr_ok = tbl[i].aok;
         mem_data_ok = tbl[i].dok; inst_addr = tbl[i].ia; mem_rdata = tbl[i].rd;
         settle();
         chk($sformatf("tbl%0d", i), {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, outst_cnt},
             {tbl[i].eia, tbl[i].eda, tbl[i].eid, tbl[i].edd, tbl[i].ec});
         adv();
      end

      // Data write stalled 3 cycles stays locked while inst_req rises
      do_reset();
      data_req = 1; data_wr = 1; data_addr = 32'h800; data_wdata = 32'hdeadbeef; inst_addr = 32'h1c000000;
      for (int i = 0; i < 3; i++) begin
         inst_req = (i >= 1);
         settle();
         chk("lock_hold", {mem_addr, mem_wr, data_addr_ok, inst_addr_ok}, {32'h800, 3'b100});
         adv();
      end
      mem_addr_ok = 1;
      settle();
      chk("lock_acc", {data_addr_ok, inst_addr_ok}, 2'b10);
      adv();
      data_req = 0;
      settle();
      chk("lock_inst", {data_addr_ok, inst_addr_ok}, 2'b01);
      adv();

      // Fill to MAX_OUTST, then one pop reopens the port a cycle later
      do_reset();
      inst_req = 1; data_req = 1; mem_addr_ok = 1;
      accepts = 0;
      for (int i = 0; i < 6; i++) begin
         settle();
         accepts += int'(inst_addr_ok) + int'(data_addr_ok);
         adv();
      end
      chk("full_accepts", accepts, MO);
      mem_data_ok = 1;
      settle();
      chk("full_pop", {mem_req, outst_cnt, inst_data_ok | data_data_ok}, {1'b0, 4'(MO), 1'b1});
      adv();
      mem_data_ok = 0;
      settle();
      chk("full_resume", {mem_req, inst_addr_ok | data_addr_ok, outst_cnt}, {2'b11, 4'(MO - 1)});
      adv();

      // Interleaved I,D,D,I accepts return to the issuing requester in order
      do_reset();
      mem_addr_ok = 1;
      for (int i = 0; i < 4; i++) begin
         inst_req = (i == 0 || i == 3);
         data_req = !inst_req;
         settle();
         adv();
      end
      inst_req = 0; data_req = 0; mem_data_ok = 1;
      ord[0] = 2'b10; ord[1] = 2'b01; ord[2] = 2'b01; ord[3] = 2'b10;
      for (int i = 0; i < 4; i++) begin
         mem_rdata = 32'h100 + i;
         settle();
         chk($sformatf("order%0d", i), {inst_data_ok, data_data_ok}, ord[i]);
         adv();
      end
      mem_data_ok = 0;

      // Response with nothing outstanding, then async reset with 2 outstanding
      do_reset();
      mem_data_ok = 1;
      settle();
      chk("err_noresp", {inst_data_ok, data_data_ok}, 2'b00);
      adv();
      mem_data_ok = 0; inst_req = 1; mem_addr_ok = 1;
      settle();
      chk("err_sticky", resp_err, 1'b1);
      adv();
      settle();
      adv();
      mem_addr_ok = 0;
      settle();
      chk("pre_reset", {outst_cnt, mem_req, resp_err}, {4'd2, 2'b11});
      #3 resetn = 0;
      #1 chk("async_reset", {resp_err, outst_cnt, mem_req}, 6'h0);
      zero_inputs();
      model_reset();
      @(negedge clk);
      resetn = 1;

      // Random traffic against the model; requests held until accepted
      hold_i = 0; hold_d = 0;
      for (int i = 0; i < 1500; i++) begin
         if (!hold_i) begin
            inst_req = $urandom_range(0, 1) == 1;
            inst_wr = $urandom_range(0, 1) == 1; inst_size = 2'($urandom_range(0, 2));
            inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
         end
         if (!hold_d) begin
            data_req = $urandom_range(0, 3) != 0;
            data_wr = $urandom_range(0, 1) == 1; data_size = 2'($urandom_range(0, 2));
            data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
         end
         mem_addr_ok = $urandom_range(0, 2) != 0;
         mem_data_ok = $urandom_range(0, 1) == 1;
         mem_rdata = $urandom;
         settle();
         hold_i = inst_req && !(e_acc && g == 0);
         hold_d = data_req && !(e_acc && g == 1);
         adv();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
